// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential arithmetic unit.
//   OP_W      : opcode width
//   opcode_e  : operation codes OP_SUMA .. OP_XOR
//   estado_e  : control FSM states (REPOSO idle, CALCULO iterating)
// Configuration macro: ALU_DIV_EN (enables the iterative divider).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SUMA  = 3'b000,
        OP_RESTA = 3'b001,
        OP_MUL   = 3'b010,
        OP_DIV   = 3'b011,
        OP_MOD   = 3'b100,
        OP_AND   = 3'b101,
        OP_OR    = 3'b110,
        OP_XOR   = 3'b111
    } opcode_e;

    typedef enum logic {
        REPOSO  = 1'b0,
        CALCULO = 1'b1
    } estado_e;

endpackage

// File: rtl/nucleo_iterativo.sv
// -----------------------------------------------------------------------------
// nucleo_iterativo
// Shared iterative engine: one 2*(ancho+1)-bit shift register, an iteration
// counter and a single add/subtract step. Multiply is shift-add (one partial
// product per cycle); divide is restoring (one quotient bit per cycle).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   cargar_i      : load operands (driven by the top FSM on an accepted start)
//   paso_i        : perform one iteration this cycle (top FSM in CALCULO)
//   modo_div_i    : 1 = divide step, 0 = multiply step (ALU_DIV_EN only)
//   a_i, b_i      : operands
//   fin_o         : this cycle performs the last iteration
//   acum_sig_o    : next value of the shift register (final result when fin_o)
// Configuration macro: ALU_DIV_EN (without it only the multiply step exists).
// -----------------------------------------------------------------------------
module nucleo_iterativo #(
    parameter int ancho = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cargar_i,
    input  logic                 paso_i,
`ifdef ALU_DIV_EN
    input  logic                 modo_div_i,
`endif
    input  logic [ancho:0]       a_i,
    input  logic [ancho:0]       b_i,
    output logic                 fin_o,
    output logic [2*ancho+1:0]   acum_sig_o
);

    localparam int W  = ancho + 1;
    localparam int CW = $clog2(ancho + 2);
    localparam logic [CW-1:0] ULTIMO = CW'(ancho);

    logic [2*W-1:0] acum_q, acum_d;
    logic [W-1:0]   operando_q, operando_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit (LSB) is set, then shift right with the carry entering at
    // the top.
    logic [W:0]     suma_mul;
    logic [2*W-1:0] paso_mul;

    always_comb begin
        suma_mul = {1'b0, acum_q[2*W-1:W]} + (acum_q[0] ? {1'b0, operando_q} : '0);
        paso_mul = {suma_mul, acum_q[W-1:1]};
    end

`ifdef ALU_DIV_EN
    logic           div_q, div_d;
    logic           cabe;
    logic [W-1:0]   resta_div;
    logic [2*W-1:0] paso_div;

    // Restoring divide step. The shifted partial remainder needs W+1 bits
    // (2r+bit can exceed W bits), so the trial compare uses the top W+1 bits.
    // When it fits, the difference is < divisor and therefore fits in W bits.
    always_comb begin
        cabe      = ({1'b0, acum_q[2*W-1:W-1]} >= {2'b0, operando_q});
        resta_div = acum_q[2*W-2:W-1] - operando_q;
        paso_div  = cabe ? {resta_div, acum_q[W-2:0], 1'b1}
                         : {acum_q[2*W-2:0], 1'b0};
    end
`endif

    always_comb begin
        acum_d     = acum_q;
        operando_d = operando_q;
        cnt_d      = cnt_q;
        fin_o      = 1'b0;
`ifdef ALU_DIV_EN
        div_d      = div_q;
`endif
        if (cargar_i) begin
            cnt_d = '0;
`ifdef ALU_DIV_EN
            div_d = modo_div_i;
            if (modo_div_i) begin
                acum_d     = {{W{1'b0}}, a_i};
                operando_d = b_i;
            end else begin
                acum_d     = {{W{1'b0}}, b_i};
                operando_d = a_i;
            end
`else
            acum_d     = {{W{1'b0}}, b_i};
            operando_d = a_i;
`endif
        end else if (paso_i) begin
`ifdef ALU_DIV_EN
            acum_d = div_q ? paso_div : paso_mul;
`else
            acum_d = paso_mul;
`endif
            fin_o = (cnt_q == ULTIMO);
            // The count reaches ancho+1 on the last step; it is cleared there
            // so the idle unit always sits at zero.
            cnt_d = fin_o ? '0 : cnt_q + 1'b1;
        end
    end

    assign acum_sig_o = acum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acum_q     <= '0;
            operando_q <= '0;
            cnt_q      <= '0;
`ifdef ALU_DIV_EN
            div_q      <= 1'b0;
`endif
        end else begin
            acum_q     <= acum_d;
            operando_q <= operando_d;
            cnt_q      <= cnt_d;
`ifdef ALU_DIV_EN
            div_q      <= div_d;
`endif
        end
    end

endmodule

// File: rtl/unidad_aritmetica_secuencial.sv
// -----------------------------------------------------------------------------
// unidad_aritmetica_secuencial
// Multi-cycle arithmetic unit feeding the ALU flag stage. add/sub/logic finish
// at the accepting edge; mul/div/mod iterate ancho+1 cycles in nucleo_iterativo.
// Handshake: a start is accepted at a rising edge where inicio=1 and listo=1;
// a, b and operacion are captured at that edge. inicio while listo=0 is
// dropped. valido pulses for one cycle when the result outputs update; the
// outputs hold their value until the next completion.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   inicio         : start request
//   operacion      : opcode (see alu_pkg::opcode_e)
//   a, b           : unsigned operands, ancho+1 bits
//   listo          : idle, start can be accepted
//   valido         : one-cycle completion pulse
//   resultado      : result
//   carryOut       : carry out of MSB (add)
//   borrowOut      : a<b unsigned (sub)
//   overflow       : signed ovf (add/sub), truncation (mul), div by zero /
//                    disabled divider (div/mod)
//   estado_dbg     : current FSM state
// Configuration macro: ALU_DIV_EN (without it div/mod complete in one cycle
// with resultado=0 and overflow=1).
// -----------------------------------------------------------------------------
module unidad_aritmetica_secuencial
    import alu_pkg::*;
#(
    parameter int ancho = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [OP_W-1:0]  operacion,
    input  logic [ancho:0]   a,
    input  logic [ancho:0]   b,
    output logic             listo,
    output logic             valido,
    output logic [ancho:0]   resultado,
    output logic             carryOut,
    output logic             borrowOut,
    output logic             overflow,
    output estado_e          estado_dbg
);

    localparam int W = ancho + 1;

    estado_e        estado_q, estado_d;
    logic           valido_q, valido_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;
`ifdef ALU_DIV_EN
    opcode_e        op_q, op_d;
`endif

    opcode_e        op_in;
    logic [W:0]     suma;
    logic [W:0]     resta;
    logic           cargar;
    logic           fin;
    logic [2*W-1:0] acum_sig;

    assign op_in = opcode_e'(operacion);
    assign suma  = {1'b0, a} + {1'b0, b};
    // Bit W of the extended difference is the unsigned borrow (a<b).
    assign resta = {1'b0, a} - {1'b0, b};

    nucleo_iterativo #(
        .ancho      (ancho)
    ) u_nucleo (
        .clk        (clk),
        .rst_n      (rst_n),
        .cargar_i   (cargar),
        .paso_i     (estado_q == CALCULO),
`ifdef ALU_DIV_EN
        .modo_div_i (op_in != OP_MUL),
`endif
        .a_i        (a),
        .b_i        (b),
        .fin_o      (fin),
        .acum_sig_o (acum_sig)
    );

    always_comb begin
        estado_d = estado_q;
        valido_d = 1'b0;
        res_d    = res_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        cargar   = 1'b0;
`ifdef ALU_DIV_EN
        op_d     = op_q;
`endif
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    // Single-cycle completions clear every flag first and set
                    // only the ones the operation defines.
                    valido_d = 1'b1;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                    ovf_d    = 1'b0;
                    unique case (op_in)
                        OP_SUMA: begin
                            res_d   = suma[W-1:0];
                            carry_d = suma[W];
                            ovf_d   = (a[W-1] == b[W-1]) && (suma[W-1] != a[W-1]);
                        end
                        OP_RESTA: begin
                            res_d    = resta[W-1:0];
                            borrow_d = resta[W];
                            ovf_d    = (a[W-1] != b[W-1]) && (resta[W-1] != a[W-1]);
                        end
                        OP_AND: res_d = a & b;
                        OP_OR:  res_d = a | b;
                        OP_XOR: res_d = a ^ b;
                        OP_MUL: begin
                            valido_d = 1'b0;
                            carry_d  = carry_q;
                            borrow_d = borrow_q;
                            ovf_d    = ovf_q;
                            cargar   = 1'b1;
                            estado_d = CALCULO;
`ifdef ALU_DIV_EN
                            op_d     = op_in;
`endif
                        end
                        OP_DIV, OP_MOD: begin
`ifdef ALU_DIV_EN
                            if (b == '0) begin
                                res_d = '1;
                                ovf_d = 1'b1;
                            end else begin
                                valido_d = 1'b0;
                                carry_d  = carry_q;
                                borrow_d = borrow_q;
                                ovf_d    = ovf_q;
                                cargar   = 1'b1;
                                estado_d = CALCULO;
                                op_d     = op_in;
                            end
`else
                            res_d = '0;
                            ovf_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            CALCULO: begin
                if (fin) begin
                    estado_d = REPOSO;
                    valido_d = 1'b1;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                    // Multiply: low half is the result, any high bit means
                    // the product was truncated.
                    res_d    = acum_sig[W-1:0];
                    ovf_d    = |acum_sig[2*W-1:W];
`ifdef ALU_DIV_EN
                    // Divide: low half holds the quotient, high the remainder.
                    if (op_q == OP_DIV) begin
                        ovf_d = 1'b0;
                    end else if (op_q == OP_MOD) begin
                        res_d = acum_sig[2*W-1:W];
                        ovf_d = 1'b0;
                    end
`endif
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            valido_q <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_DIV_EN
            op_q     <= OP_SUMA;
`endif
        end else begin
            estado_q <= estado_d;
            valido_q <= valido_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
`ifdef ALU_DIV_EN
            op_q     <= op_d;
`endif
        end
    end

    assign listo      = (estado_q == REPOSO);
    assign valido     = valido_q;
    assign resultado  = res_q;
    assign carryOut   = carry_q;
    assign borrowOut  = borrow_q;
    assign overflow   = ovf_q;
    assign estado_dbg = estado_q;

endmodule

// File: tb/tb_unidad_aritmetica_secuencial.sv
// -----------------------------------------------------------------------------
// tb_unidad_aritmetica_secuencial
// Directed bench for unidad_aritmetica_secuencial with ancho=3 (4-bit data).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_unidad_aritmetica_secuencial;
    import alu_pkg::*;

    localparam int ANCHO = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inicio = 1'b0;
    logic [OP_W-1:0]  operacion = '0;
    logic [ANCHO:0]   a = '0;
    logic [ANCHO:0]   b = '0;
    logic             listo;
    logic             valido;
    logic [ANCHO:0]   resultado;
    logic             carryOut;
    logic             borrowOut;
    logic             overflow;
    estado_e          estado_dbg;

    int n_cmp = 0;
    int n_err = 0;

    unidad_aritmetica_secuencial #(
        .ancho      (ANCHO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inicio     (inicio),
        .operacion  (operacion),
        .a          (a),
        .b          (b),
        .listo      (listo),
        .valido     (valido),
        .resultado  (resultado),
        .carryOut   (carryOut),
        .borrowOut  (borrowOut),
        .overflow   (overflow),
        .estado_dbg (estado_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic salidas(input string tag, input logic v, input logic l,
                           input logic [3:0] r, input logic c, input logic bo,
                           input logic o);
        chk({tag, "_valido"},    8'(valido),    8'(v));
        chk({tag, "_listo"},     8'(listo),     8'(l));
        chk({tag, "_resultado"}, 8'(resultado), 8'(r));
        chk({tag, "_carry"},     8'(carryOut),  8'(c));
        chk({tag, "_borrow"},    8'(borrowOut), 8'(bo));
        chk({tag, "_overflow"},  8'(overflow),  8'(o));
    endtask

    task automatic flanco();
        @(posedge clk);
        #1;
    endtask

    task automatic poner(input logic ini, input opcode_e op,
                         input logic [3:0] aa, input logic [3:0] bb);
        inicio    = ini;
        operacion = op;
        a         = aa;
        b         = bb;
    endtask

    initial begin
        opcode_e op_it;

        // Reset state
        repeat (2) flanco();
        salidas("reset", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_estado", 8'(estado_dbg), 8'(REPOSO));
        rst_n = 1'b1;
        flanco();

        // add with signed overflow: 7+1 = 8
        poner(1'b1, OP_SUMA, 4'b0111, 4'b0001);
        flanco();
        salidas("add_7_1", 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();
        chk("add_pulso_valido", 8'(valido), 8'h0);
        chk("add_hold_res", 8'(resultado), 8'h8);

        // sub with borrow, then add back-to-back on the next edge
        poner(1'b1, OP_RESTA, 4'b0010, 4'b0101);
        flanco();
        salidas("sub_2_5", 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0);
        poner(1'b1, OP_SUMA, 4'b1111, 4'b0001);
        flanco();
        salidas("add_f_1", 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

        // logic ops, all flags 0
        poner(1'b1, OP_AND, 4'b1100, 4'b1010);
        flanco();
        salidas("and", 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        poner(1'b1, OP_OR, 4'b1100, 4'b1010);
        flanco();
        salidas("or", 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        poner(1'b1, OP_XOR, 4'b1100, 4'b1010);
        flanco();
        salidas("xor", 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();

        // mul 5*3 = 15, no truncation
        poner(1'b1, OP_MUL, 4'b0101, 4'b0011);
        flanco();
        chk("mul1_t0_listo", 8'(listo), 8'h0);
        chk("mul1_t0_valido", 8'(valido), 8'h0);
        chk("mul1_t0_estado", 8'(estado_dbg), 8'(CALCULO));
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        for (int i = 1; i <= 3; i++) begin
            flanco();
            chk($sformatf("mul1_t%0d_listo", i), 8'(listo), 8'h0);
            chk($sformatf("mul1_t%0d_valido", i), 8'(valido), 8'h0);
        end
        flanco();
        salidas("mul_5_3", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);

        // mul 6*3 = 18 -> low 0010, truncated
        poner(1'b1, OP_MUL, 4'b0110, 4'b0011);
        flanco();
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        repeat (3) flanco();
        chk("mul2_t3_valido", 8'(valido), 8'h0);
        flanco();
        salidas("mul_6_3", 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);

`ifdef ALU_DIV_EN
        // div 13/4 = 3, mod = 1
        poner(1'b1, OP_DIV, 4'b1101, 4'b0100);
        flanco();
        chk("div_t0_listo", 8'(listo), 8'h0);
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        repeat (3) flanco();
        flanco();
        salidas("div_13_4", 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        poner(1'b1, OP_MOD, 4'b1101, 4'b0100);
        flanco();
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        repeat (3) flanco();
        flanco();
        salidas("mod_13_4", 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        // divide by zero completes at t0
        poner(1'b1, OP_DIV, 4'b1101, 4'b0000);
        flanco();
        salidas("div_cero", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
`else
        // divider absent: div/mod complete at t0 with resultado 0, overflow 1
        poner(1'b1, OP_DIV, 4'b1101, 4'b0100);
        flanco();
        salidas("div_off", 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        poner(1'b1, OP_MOD, 4'b1101, 4'b0100);
        flanco();
        salidas("mod_off", 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        poner(1'b1, OP_DIV, 4'b1101, 4'b0000);
        flanco();
        salidas("div_cero_off", 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
`endif
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();
        chk("div_cero_pulso", 8'(valido), 8'h0);

        // inicio held high during a mul (3*2=6); add 1+1 is retried every edge
        poner(1'b1, OP_MUL, 4'b0011, 4'b0010);
        flanco();
        chk("ign_t0_listo", 8'(listo), 8'h0);
        poner(1'b1, OP_SUMA, 4'b0001, 4'b0001);
        for (int i = 1; i <= 3; i++) begin
            flanco();
            chk($sformatf("ign_t%0d_valido", i), 8'(valido), 8'h0);
            chk($sformatf("ign_t%0d_listo", i), 8'(listo), 8'h0);
        end
        flanco();
        salidas("ign_t4_mul", 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        flanco();
        salidas("ign_t5_add", 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();
        chk("ign_t6_valido", 8'(valido), 8'h0);

        // reset during an iterative operation
`ifdef ALU_DIV_EN
        op_it = OP_DIV;
`else
        op_it = OP_MUL;
`endif
        poner(1'b1, op_it, 4'b1101, 4'b0100);
        flanco();
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();
        flanco();
        chk("abort_pre_listo", 8'(listo), 8'h0);
        rst_n = 1'b0;
        #1;
        salidas("abort", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("abort_estado", 8'(estado_dbg), 8'(REPOSO));
        flanco();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            flanco();
            chk($sformatf("abort_sin_valido_%0d", i), 8'(valido), 8'h0);
            chk($sformatf("abort_listo_%0d", i), 8'(listo), 8'h1);
        end

        // normal add after the abort: 3+4 = 7
        poner(1'b1, OP_SUMA, 4'b0011, 4'b0100);
        flanco();
        salidas("add_post_reset", 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
        poner(1'b0, OP_SUMA, 4'h0, 4'h0);
        flanco();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidad_aritmetica_secuencial.md
# unidad_aritmetica_secuencial

Multi-cycle arithmetic unit feeding the flag controller of the ALU datapath. Accepts two operands and an opcode under a start/ready handshake. Computes add, subtract and logic ops in one cycle, and multiply, divide and modulo iteratively. Registers `resultado`, `carryOut`, `borrowOut` and `overflow` for the flag stage, which derives N, Z, C and V from them.

## Interface
- `ancho`, default 3: MSB index of the data path (data width = ancho+1).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `inicio`  in  1  start request; sampled only while `listo`=1
- `operacion`  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor
- `a`, `b`  in  ancho+1  unsigned operands (signed view used only for `overflow` on add/sub)
- `listo`  out  1  unit idle, can accept `inicio`
- `valido`  out  1  one-cycle pulse: outputs below just updated
- `resultado`  out  ancho+1  result
- `carryOut`  out  1  carry out of MSB (add only)
- `borrowOut`  out  1  borrow, a<b unsigned (sub only)
- `overflow`  out  1  signed overflow (add/sub), truncation (mul), divide-by-zero/illegal (div/mod)

## Operation
- FSM states: REPOSO, CALCULO, with `listo`=1 only in REPOSO.
  - REPOSO→CALCULO on an accepted start with opcode mul/div/mod.
  - CALCULO→REPOSO after the iteration count reaches ancho+1.
- Start accepted at an edge where `inicio`=1 and state=REPOSO. `a`, `b` and `operacion` are captured at that edge.
- `inicio` in CALCULO is ignored, with no queuing.
- add: `resultado`=(a+b) mod 2^(ancho+1). `carryOut`=bit ancho+1 of the sum. `overflow`=signs of a and b equal and result sign differs.
- sub: `resultado`=(a−b) mod 2^(ancho+1). `borrowOut`=(a<b). `overflow`=signs of a and b differ and result sign differs from a.
- mul: shift-add, one partial product per cycle. `resultado`=low ancho+1 bits. `overflow`=high half ≠0.
- div/mod: restoring division, one quotient bit per cycle. `resultado`=quotient (div) or remainder (mod).
  - b=0: single-cycle completion, `resultado`=all ones, `overflow`=1.
- Logic ops: bitwise result.
- Every flag not defined for the executed op is driven 0 at completion.
- Outputs hold their value between completions.

## Timing
- Reset (async assert, sync release) forces:
  - `listo`=1, `valido`=0, `resultado`=0, all flags 0
  - state REPOSO, iteration counter 0
- Reset asserted mid-CALCULO aborts the operation with no `valido` pulse.
- Single-cycle ops (add, sub, logic, div/mod by zero): outputs and `valido`=1 registered at the accepting edge t0. `listo` stays 1.
  - Back-to-back starts on consecutive edges each produce a result.
- Iterative ops: `listo`=0 from t0. Results, `valido`=1 and `listo`=1 are registered at edge t0+ancho+1.
  - A new start is accepted no earlier than edge t0+ancho+2.
- `valido` is never high for two consecutive cycles from one start.
- Iteration counter width is $clog2(ancho+2). Partial-product and remainder registers are 2·(ancho+1) bits wide.

## Configuration
- `ALU_DIV_EN`
  - Defined: div/mod as specified above.
  - Undefined: no divider logic. Opcodes 011/100 complete single-cycle with `resultado`=0, `overflow`=1, other flags 0.

## Structure
- Package `alu_pkg`:
  - opcode enum (`OP_SUMA` … `OP_XOR`)
  - FSM state enum
  - opcode width constant
- One sub-module, `nucleo_iterativo`, holds the shared shift register, counter and add/subtract step for mul and div/mod.
  - Its start/done is driven by the top FSM.
  - Its body for the divide step is guarded by `ALU_DIV_EN`.

## Test plan
- ancho=3, add a=0111, b=0001 → at t0: `resultado`=1000, `overflow`=1, `carryOut`=0, `valido` 1 cycle.
- sub a=0010, b=0101 → `resultado`=1101, `borrowOut`=1, `overflow`=0. Then add a=1111, b=0001 on the next edge → `resultado`=0000, `carryOut`=1.
- mul a=0101, b=0011 → `listo` low 4 cycles, `resultado`=1111, `overflow`=0. Then mul a=0110, b=0011 → `resultado`=0010, `overflow`=1.
- div a=1101, b=0100 → quotient 0011. mod, same operands → 0001. div with b=0 → `resultado`=1111, `overflow`=1 in a single cycle.
- `inicio` pulsed every cycle during a mul → ignored. Exactly one `valido`, and the next start is accepted at t0+5.
- `rst_n` low at cycle 2 of a div → all outputs zero and `listo`=1 immediately. No `valido`. A following add completes normally.
